// File: rtl/copro_result_buffer.sv
// Result buffer between coprocessor execution units and the CV-X-IF result channel.
// In-order FIFO that sanitises ILLEGAL/NOP entries before presenting them to the core.
module copro_result_buffer #(
  parameter int DEPTH    = 4,
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 3,
  parameter int RD_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ID_WIDTH-1:0]      in_id_i,
  input  logic [XLEN-1:0]          in_data_i,
  input  logic [RD_WIDTH-1:0]      in_rd_i,
  input  logic                     in_we_i,
  input  logic [3:0]               in_opcode_i,
  input  logic                     flush_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [ID_WIDTH-1:0]      result_id_o,
  output logic [XLEN-1:0]          result_data_o,
  output logic [RD_WIDTH-1:0]      result_rd_o,
  output logic                     result_we_o,
  output logic                     result_exc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_COUNT = PW'(DEPTH);
  localparam logic [3:0]    OP_ILLEGAL = 4'b0000;
  localparam logic [3:0]    OP_NOP     = 4'b0001;

  typedef struct packed {
    logic                exc;
    logic                we;
    logic [RD_WIDTH-1:0] rd;
    logic [ID_WIDTH-1:0] id;
    logic [XLEN-1:0]     data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic            push;
  logic            pop;

  // Extra pointer bit makes the difference DEPTH when full and 0 when empty.
  assign count          = wr_ptr - rd_ptr;
  assign count_o        = count;
  assign in_ready_o     = (count != FULL_COUNT);
  assign result_valid_o = (count != '0);

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = result_valid_o & result_ready_i & ~flush_i;

  always_comb begin
    wr_entry      = '0;
    wr_entry.id   = in_id_i;
    wr_entry.rd   = in_rd_i;
    wr_entry.data = in_data_i;
    wr_entry.we   = in_we_i;
    wr_entry.exc  = 1'b0;
    if (in_opcode_i == OP_ILLEGAL) begin
      wr_entry.exc  = 1'b1;
      wr_entry.we   = 1'b0;
      wr_entry.data = '0;
    end else if (in_opcode_i == OP_NOP) begin
      wr_entry.we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; stale slots are never visible because outputs are gated by valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  assign head = result_valid_o ? mem[rd_ptr[AW-1:0]] : '0;

  assign result_id_o   = head.id;
  assign result_data_o = head.data;
  assign result_rd_o   = head.rd;
  assign result_we_o   = head.we;
  assign result_exc_o  = head.exc;

endmodule

// File: tb/tb_copro_result_buffer.sv
// Scoreboard bench for copro_result_buffer: stimulus queues expected results,
// a negedge monitor checks every accepted result against the queue head.
module tb_copro_result_buffer;

  localparam int DEPTH = 4, XLEN = 32, IDW = 3, RDW = 5;
  localparam logic [3:0] OP_ILL = 4'b0000, OP_NOP = 4'b0001;
  localparam logic [3:0] OP_RORH = 4'h2, OP_RORL = 4'h3;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [XLEN-1:0] data;
    logic [RDW-1:0]  rd;
    logic            we;
    logic            exc;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0, in_ready;
  logic [IDW-1:0]  in_id = '0;
  logic [XLEN-1:0] in_data = '0;
  logic [RDW-1:0]  in_rd = '0;
  logic in_we = 0;
  logic [3:0] in_op = '0;
  logic flush = 0;
  logic res_valid, res_ready = 0;
  logic [IDW-1:0]  res_id;
  logic [XLEN-1:0] res_data;
  logic [RDW-1:0]  res_rd;
  logic res_we, res_exc;
  logic [2:0] count;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  copro_result_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_WIDTH(IDW), .RD_WIDTH(RDW)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_id_i(in_id), .in_data_i(in_data), .in_rd_i(in_rd), .in_we_i(in_we),
    .in_opcode_i(in_op), .flush_i(flush),
    .result_valid_o(res_valid), .result_ready_i(res_ready),
    .result_id_o(res_id), .result_data_o(res_data), .result_rd_o(res_rd),
    .result_we_o(res_we), .result_exc_o(res_exc), .count_o(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat; queue the hand-computed expected result if it will be accepted.
  task automatic drive(input logic v, input logic [IDW-1:0] id, input logic [XLEN-1:0] data,
                       input logic [RDW-1:0] rd, input logic we, input logic [3:0] op,
                       input logic exp_we, input logic exp_exc, input logic [XLEN-1:0] exp_data);
    exp_t e;
    in_valid = v; in_id = id; in_data = data; in_rd = rd; in_we = we; in_op = op;
    if (v && in_ready && !flush && !rst) begin
      e.id = id; e.data = exp_data; e.rd = rd; e.we = exp_we; e.exc = exp_exc;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, OP_RORH, 1'b0, 1'b0, '0);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (count != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_to_empty", 64'(count), 64'd0);
  endtask

  // Monitor: inputs are stable mid-cycle, so negedge sees exactly what the next posedge consumes.
  always @(negedge clk) begin
    if (!rst && !flush && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id=%0d data=0x%0h, expected no result", res_id, res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_id",   64'(res_id),   64'(e.id));
        chk("res_data", 64'(res_data), 64'(e.data));
        chk("res_rd",   64'(res_rd),   64'(e.rd));
        chk("res_we",   64'(res_we),   64'(e.we));
        chk("res_exc",  64'(res_exc),  64'(e.exc));
      end
    end
  end

  initial begin
    // Reset
    rst = 1;
    step(); step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_outs", {res_id, res_data, res_rd, res_we, res_exc}, 64'd0);
    rst = 0;
    step();

    // Single push with ready high: visible one cycle later, then gone
    res_ready = 1;
    drive(1, 3'd2, 32'hDEADBEEF, 5'd10, 1, OP_RORH, 1, 0, 32'hDEADBEEF);
    chk("no_bypass_valid", 64'(res_valid), 64'd0);
    step();
    idle();
    chk("single_valid", 64'(res_valid), 64'd1);
    chk("single_count", 64'(count), 64'd1);
    step();
    chk("single_count_after", 64'(count), 64'd0);
    chk("single_valid_after", 64'(res_valid), 64'd0);

    // Fill to full, reject fifth, drain in order
    res_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, IDW'(i), 32'h100 + i, RDW'(i + 1), 1, OP_RORL, 1, 0, 32'h100 + i);
      step();
    end
    idle();
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    drive(1, 3'd7, 32'hBAD, 5'd7, 1, OP_RORL, 1, 0, 32'hBAD);
    step();
    idle();
    chk("full_reject_count", 64'(count), 64'd4);
    res_ready = 1;
    wait_empty(10);

    // Full with simultaneous pop and attempted push
    res_ready = 0;
    for (int i = 4; i < 8; i++) begin
      drive(1, IDW'(i), 32'h200 + i, RDW'(i), 1, OP_RORH, 1, 0, 32'h200 + i);
      step();
    end
    res_ready = 1;
    drive(1, 3'd1, 32'hBAD2, 5'd1, 1, OP_RORH, 1, 0, 32'hBAD2);
    chk("full_pop_ready", 64'(in_ready), 64'd0);
    step();
    idle();
    chk("full_pop_count", 64'(count), 64'd3);
    wait_empty(10);

    // ILLEGAL and NOP sanitising
    drive(1, 3'd5, 32'h1234, 5'd3, 1, OP_ILL, 0, 1, 32'h0);
    step();
    chk("illegal_exc", 64'(res_exc), 64'd1);
    drive(1, 3'd6, 32'h55, 5'd4, 1, OP_NOP, 0, 0, 32'h55);
    step();
    idle();
    wait_empty(10);

    // Flush mid-stream with an incoming beat
    res_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, IDW'(i), 32'h300 + i, RDW'(i), 1, OP_RORL, 1, 0, 32'h300 + i);
      step();
    end
    chk("preflush_count", 64'(count), 64'd3);
    flush = 1;
    drive(1, 3'd4, 32'h304, 5'd4, 1, OP_RORL, 1, 0, 32'h304);
    sb.delete();
    step();
    flush = 0;
    idle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(res_valid), 64'd0);
    res_ready = 1;
    step(); step(); step();
    chk("flush_discard", 64'(count), 64'd0);

    // Six back-to-back push/pop pairs across the pointer wrap
    for (int i = 0; i < 6; i++) begin
      drive(1, IDW'(i), 32'hA0 + i, RDW'(20 + i), 1, OP_RORH, 1, 0, 32'hA0 + i);
      step();
      chk("stream_count", 64'(count), 64'd1);
    end
    idle();
    wait_empty(10);

    // Reset with two entries pending
    res_ready = 0;
    for (int i = 0; i < 2; i++) begin
      drive(1, IDW'(i + 3), 32'hC0 + i, RDW'(i), 1, OP_RORL, 1, 0, 32'hC0 + i);
      step();
    end
    idle();
    chk("prereset_count", 64'(count), 64'd2);
    rst = 1;
    sb.delete();
    step();
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_valid", 64'(res_valid), 64'd0);
    chk("midrst_outs", {res_id, res_data, res_rd, res_we, res_exc}, 64'd0);
    rst = 0;
    res_ready = 1;
    step(); step(); step();
    chk("postrst_count", 64'(count), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
